// File: rtl/core_pkg.sv
// Shared encodings for the memory-port arbiter: access sizes, owner tags, arbiter states and
// the size/alignment legality check.
package core_pkg;

    localparam logic [1:0] HB_WORD = 2'b00;
    localparam logic [1:0] HB_BYTE = 2'b01;
    localparam logic [1:0] HB_HALF = 2'b10;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        RESP_ERR
    } arb_state_e;

    // Misaligned half/word, or the reserved size code.
    function automatic logic size_err(input logic [1:0] hb, input logic [1:0] lsb);
        case (hb)
            HB_WORD: return lsb != 2'b00;
            HB_HALF: return lsb[0];
            HB_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it; words pass
// through unchanged.
module load_formatter
    import core_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  hb_i,
    input  logic        ul_i,
    output logic [31:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = word_i[{addr_i, 3'b000} +: 8];
    assign w_half = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        result_o = word_i;
        case (hb_i)
            HB_BYTE: result_o = {{24{~ul_i & w_byte[7]}}, w_byte};
            HB_HALF: result_o = {{16{~ul_i & w_half[15]}}, w_half};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses: one outstanding
// transaction, data-over-fetch priority with a starvation guard, lane steering and load extension.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_hb_i,
    input  logic        d_ul_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    arb_state_e  r_state, w_state_nxt;
    logic [3:0]  r_starve;
    logic        r_owner, r_we, r_ul;
    logic [1:0]  r_hb;
    logic [31:0] r_addr, r_wdata, r_rdata;

    logic        w_idle, w_pick_if, w_d_err, w_issue, w_resp_d;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;

    // Gated by rst_ni so the combinational grants also read 0 while reset is held.
    assign w_idle    = (r_state == IDLE) && rst_ni;
    assign w_pick_if = if_req_i && (!d_req_i || (r_starve == Limit));
    assign if_gnt_o  = w_idle && w_pick_if;
    assign d_gnt_o   = w_idle && d_req_i && !w_pick_if;
    assign w_d_err   = size_err(d_hb_i, d_addr_i[1:0]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (if_gnt_o) begin
                    w_state_nxt = ISSUE;
                end else if (d_gnt_o) begin
                    w_state_nxt = w_d_err ? RESP_ERR : ISSUE;
                end
            end
            ISSUE:    if (mem_gnt_i) w_state_nxt = WAIT;
            WAIT:     if (mem_rvalid_i) w_state_nxt = RESP;
            RESP:     w_state_nxt = IDLE;
            RESP_ERR: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!if_req_i || if_gnt_o) begin
                r_starve <= '0;
            end else if (d_gnt_o && (r_starve != Limit)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    // Fetches are latched as aligned-irrelevant word reads so the lane logic yields 1111.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= OWNER_IF;
            r_we    <= 1'b0;
            r_ul    <= 1'b0;
            r_hb    <= HB_WORD;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (if_gnt_o) begin
            r_owner <= OWNER_IF;
            r_we    <= 1'b0;
            r_ul    <= 1'b0;
            r_hb    <= HB_WORD;
            r_addr  <= if_addr_i;
            r_wdata <= '0;
        end else if (d_gnt_o) begin
            r_owner <= OWNER_D;
            r_we    <= d_we_i;
            r_ul    <= d_ul_i;
            r_hb    <= d_hb_i;
            r_addr  <= d_addr_i;
            r_wdata <= d_wdata_i;
        end
    end

    load_formatter u_load_formatter (
        .word_i   (mem_rdata_i),
        .addr_i   (r_addr[1:0]),
        .hb_i     (r_hb),
        .ul_i     (r_ul),
        .result_o (w_load)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if ((r_state == WAIT) && mem_rvalid_i) begin
            if (r_owner == OWNER_IF) begin
                r_rdata <= mem_rdata_i;
            end else begin
                r_rdata <= r_we ? 32'd0 : w_load;
            end
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_hb)
            HB_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            HB_HALF: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    assign w_issue     = (r_state == ISSUE);
    assign mem_req_o   = w_issue;
    assign mem_we_o    = w_issue && r_we;
    assign mem_addr_o  = w_issue ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_be_o    = w_issue ? w_be : 4'b0000;
    assign mem_wdata_o = w_issue ? w_wdata : 32'd0;

    assign w_resp_d    = (r_state == RESP) && (r_owner == OWNER_D);
    assign if_rvalid_o = (r_state == RESP) && (r_owner == OWNER_IF);
    assign if_rdata_o  = if_rvalid_o ? r_rdata : 32'd0;
    assign d_rvalid_o  = w_resp_d || (r_state == RESP_ERR);
    assign d_err_o     = (r_state == RESP_ERR);
    assign d_rdata_o   = w_resp_d ? r_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized single-requester
// traffic checked against an arithmetic model of lanes, extension and error rules.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        d_req_i, d_we_i, d_ul_i, d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [1:0]  d_hb_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit          got_gnt;
        logic        req_seen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        own_rv;
        logic        other_rv;
        logic        err;
        logic [31:0] rdata;
        logic        extra_rv;
    } obs_t;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_hb_i       (d_hb_i),
        .d_ul_i       (d_ul_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .d_err_o      (d_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    logic [138:0] all_out;
    assign all_out = {if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
                      mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};

    // Reference model: access size in bytes drives every lane/extension rule.
    function automatic int unsigned nbytes(input logic [1:0] hb);
        return (hb == 2'b01) ? 1 : (hb == 2'b10) ? 2 : 4;
    endfunction

    function automatic bit m_err(input logic [1:0] hb, input logic [31:0] a);
        return (hb == 2'b11) || ((a % nbytes(hb)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] hb, input logic [31:0] a);
        int unsigned n = nbytes(hb);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] hb, input logic [31:0] w);
        int unsigned n = nbytes(hb);
        longint unsigned mask = (64'd1 << (8 * n)) - 1;
        longint unsigned v = longint'(w) & mask;
        longint unsigned r = 0;
        for (int k = 0; k < int'(4 / n); k++) r = r | (v << (8 * n * k));
        return 32'(r);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] hb, input logic ul);
        int unsigned n = nbytes(hb);
        longint unsigned mask = (64'd1 << (8 * n)) - 1;
        longint unsigned v = (longint'(word) >> (8 * (a % 4))) & mask;
        if (!ul && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~mask;
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one access as a lone requester and plays the bus; returns what was observed.
    task automatic txn(input bit use_if, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] hb, input logic ul,
                       input logic [31:0] rword, input int gl, input int rl, output obs_t o);
        int waitc = 0;
        o = '{default: 0};
        if (use_if) begin
            if_req_i = 1'b1; if_addr_i = addr;
        end else begin
            d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
            d_hb_i = hb; d_ul_i = ul;
        end
        #1;
        while (!(use_if ? if_gnt_o : d_gnt_o) && waitc < 20) begin
            step();
            #1;
            waitc++;
        end
        o.got_gnt = use_if ? if_gnt_o : d_gnt_o;
        if (!o.got_gnt) begin
            if_req_i = 1'b0; d_req_i = 1'b0;
            return;
        end
        step();
        if_req_i = 1'b0; d_req_i = 1'b0;
        if_addr_i = $urandom; d_addr_i = $urandom; d_wdata_i = $urandom;
        d_hb_i = 2'($urandom); d_ul_i = 1'($urandom); d_we_i = 1'($urandom);
        #1;
        o.req_seen = mem_req_o; o.addr = mem_addr_o; o.be = mem_be_o;
        o.we = mem_we_o; o.wdata = mem_wdata_o;
        if (!mem_req_o) begin
            o.own_rv = use_if ? if_rvalid_o : d_rvalid_o;
            o.other_rv = use_if ? d_rvalid_o : if_rvalid_o;
            o.err = d_err_o; o.rdata = use_if ? if_rdata_o : d_rdata_o;
            step();
            o.extra_rv = if_rvalid_o | d_rvalid_o;
            return;
        end
        repeat (gl) step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        repeat (rl) step();
        mem_rvalid_i = 1'b1; mem_rdata_i = rword;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        o.own_rv = use_if ? if_rvalid_o : d_rvalid_o;
        o.other_rv = use_if ? d_rvalid_o : if_rvalid_o;
        o.err = d_err_o; o.rdata = use_if ? if_rdata_o : d_rdata_o;
        step();
        o.extra_rv = if_rvalid_o | d_rvalid_o;
    endtask

    task automatic test_reset();
        n_total++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else n_pass++;
        rst_ni = 1'b1;
        step();
        n_total++;
        if (all_out !== '0) $display("FAIL post_reset_idle: got %h want 0", all_out);
        else n_pass++;
    endtask

    task automatic test_fetch();
        obs_t o;
        txn(1'b1, 1'b0, 32'h0000_0106, 32'd0, 2'b00, 1'b0, 32'h00A0_0093, 0, 0, o);
        n_total++;
        if (o.addr !== 32'h104 || o.be !== 4'b1111 || o.we !== 1'b0 || o.req_seen !== 1'b1)
            $display("FAIL fetch_bus: got addr=%h be=%b we=%b req=%b want 104/1111/0/1",
                     o.addr, o.be, o.we, o.req_seen);
        else n_pass++;
        n_total++;
        if (o.own_rv !== 1'b1 || o.rdata !== 32'h00A0_0093 || o.other_rv !== 1'b0)
            $display("FAIL fetch_resp: got rv=%b rdata=%h drv=%b want 1/00a00093/0",
                     o.own_rv, o.rdata, o.other_rv);
        else n_pass++;
        n_total++;
        if (o.extra_rv !== 1'b0) $display("FAIL fetch_pulse: got %b want 0", o.extra_rv);
        else n_pass++;
    endtask

    task automatic test_byte_load();
        obs_t o;
        logic [31:0] want [2];
        want[0] = 32'hFFFF_FF80;
        want[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            txn(1'b0, 1'b0, 32'h203, 32'd0, 2'b01, 1'(u), 32'h80FF_1234, 0, 0, o);
            n_total++;
            if (o.be !== 4'b1000 || o.addr !== 32'h200)
                $display("FAIL byte_bus ul=%0d: got be=%b addr=%h want 1000/200", u, o.be, o.addr);
            else n_pass++;
            n_total++;
            if (o.own_rv !== 1'b1 || o.rdata !== want[u] || o.err !== 1'b0)
                $display("FAIL byte_rdata ul=%0d: got rv=%b rdata=%h err=%b want 1/%h/0",
                         u, o.own_rv, o.rdata, o.err, want[u]);
            else n_pass++;
        end
    endtask

    task automatic test_half_store();
        obs_t o;
        txn(1'b0, 1'b1, 32'h302, 32'h1234_ABCD, 2'b10, 1'b0, 32'h5555_5555, 1, 2, o);
        n_total++;
        if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hABCD_ABCD || o.addr !== 32'h300)
            $display("FAIL half_store_bus: got we=%b be=%b wdata=%h addr=%h want 1/1100/abcdabcd/300",
                     o.we, o.be, o.wdata, o.addr);
        else n_pass++;
        n_total++;
        if (o.own_rv !== 1'b1 || o.rdata !== 32'd0 || o.err !== 1'b0)
            $display("FAIL half_store_resp: got rv=%b rdata=%h err=%b want 1/0/0",
                     o.own_rv, o.rdata, o.err);
        else n_pass++;
    endtask

    task automatic test_starvation();
        bit q[$];
        int dbl = 0;
        bit pend = 0;
        if_req_i = 1'b1; if_addr_i = 32'h40; d_req_i = 1'b1; d_we_i = 1'b0;
        d_addr_i = 32'h80; d_hb_i = 2'b00; d_ul_i = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (q.size() >= 10) begin
                if_req_i = 1'b0; d_req_i = 1'b0;
            end
            #1;
            if (if_gnt_o && d_gnt_o) dbl++;
            if (if_gnt_o) q.push_back(1'b1);
            else if (d_gnt_o) q.push_back(1'b0);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (pend) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = $urandom; pend = 0;
            end
            if (mem_req_o) begin
                mem_gnt_i = 1'b1; pend = 1;
            end
            @(posedge clk_i);
        end
        #1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        n_total++;
        if (dbl !== 0) $display("FAIL starve_double_gnt: got %0d cycles want 0", dbl);
        else n_pass++;
        n_total++;
        if (q.size() < 10) $display("FAIL starve_count: got %0d grants want 10", q.size());
        else n_pass++;
        for (int i = 0; i < 10 && i < q.size(); i++) begin
            bit exp_if = (((i + 1) % (LIMIT + 1)) == 0);
            n_total++;
            if (q[i] !== exp_if)
                $display("FAIL starve_order[%0d]: got if=%0d want if=%0d", i, q[i], exp_if);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        txn(1'b0, 1'b0, 32'h401, 32'd0, 2'b00, 1'b0, 32'hDEAD_BEEF, 0, 0, o);
        n_total++;
        if (o.got_gnt !== 1'b1 || o.req_seen !== 1'b0)
            $display("FAIL misalign_nobus: got gnt=%b req=%b want 1/0", o.got_gnt, o.req_seen);
        else n_pass++;
        n_total++;
        if (o.own_rv !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'd0 || o.extra_rv !== 1'b0)
            $display("FAIL misalign_resp: got rv=%b err=%b rdata=%h extra=%b want 1/1/0/0",
                     o.own_rv, o.err, o.rdata, o.extra_rv);
        else n_pass++;
        txn(1'b1, 1'b0, 32'h0000_0808, 32'd0, 2'b00, 1'b0, 32'h1357_9BDF, 0, 1, o);
        n_total++;
        if (o.addr !== 32'h808 || o.own_rv !== 1'b1 || o.rdata !== 32'h1357_9BDF || o.err !== 1'b0)
            $display("FAIL misalign_next_fetch: got addr=%h rv=%b rdata=%h err=%b want 808/1/13579bdf/0",
                     o.addr, o.own_rv, o.rdata, o.err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int waitc = 0;
        logic seen = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500; d_hb_i = 2'b00; d_ul_i = 1'b0;
        #1;
        while (!d_gnt_o && waitc < 20) begin
            step();
            #1;
            waitc++;
        end
        n_total++;
        if (d_gnt_o !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", d_gnt_o);
        else n_pass++;
        step();
        d_req_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if (all_out !== '0) $display("FAIL rstmid_outputs: got %h want 0", all_out);
        else n_pass++;
        step();
        n_total++;
        if (all_out !== '0) $display("FAIL rstmid_outputs_held: got %h want 0", all_out);
        else n_pass++;
        rst_ni = 1'b1;
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        step();
        mem_rvalid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen = seen | if_rvalid_o | d_rvalid_o | mem_req_o;
            step();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rstmid_late_rvalid: got activity=%b want 0", seen);
        else n_pass++;
        txn(1'b1, 1'b0, 32'h0000_0C04, 32'd0, 2'b00, 1'b0, 32'h2468_ACE0, 0, 0, o);
        n_total++;
        if (o.own_rv !== 1'b1 || o.rdata !== 32'h2468_ACE0)
            $display("FAIL rstmid_recover: got rv=%b rdata=%h want 1/2468ace0", o.own_rv, o.rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            bit          use_if = ($urandom_range(0, 3) == 0);
            logic        we     = 1'($urandom_range(0, 1));
            logic [31:0] a      = $urandom;
            logic [31:0] w      = $urandom;
            logic [31:0] rw     = $urandom;
            logic [1:0]  hb     = 2'($urandom_range(0, 3));
            logic        ul     = 1'($urandom_range(0, 1));
            int          gl     = $urandom_range(0, 2);
            int          rl     = $urandom_range(0, 2);
            bit          e_err;
            logic [31:0] e_rd;
            // Bias data addresses toward legal alignment so most accesses reach the bus.
            if ($urandom_range(0, 2) != 0) a = a & ~32'((nbytes(hb) - 1));
            e_err = !use_if && m_err(hb, a);
            e_rd  = use_if ? rw : (e_err || we) ? 32'd0 : m_load(rw, a, hb, ul);
            txn(use_if, we, a, w, hb, ul, rw, gl, rl, o);
            n_total++;
            if (o.got_gnt !== 1'b1 || o.req_seen !== !e_err)
                $display("FAIL rand[%0d]_issue: got gnt=%b req=%b want 1/%b",
                         i, o.got_gnt, o.req_seen, !e_err);
            else n_pass++;
            if (!e_err) begin
                n_total++;
                if (o.addr !== {a[31:2], 2'b00} || o.be !== (use_if ? 4'hF : m_be(hb, a)) ||
                    o.we !== (!use_if && we))
                    $display("FAIL rand[%0d]_bus: got addr=%h be=%b we=%b want %h/%b/%b", i,
                             o.addr, o.be, o.we, {a[31:2], 2'b00},
                             use_if ? 4'hF : m_be(hb, a), !use_if && we);
                else n_pass++;
            end
            if (!use_if && we && !e_err) begin
                n_total++;
                if (o.wdata !== m_wdata(hb, w))
                    $display("FAIL rand[%0d]_wdata: got %h want %h", i, o.wdata, m_wdata(hb, w));
                else n_pass++;
            end
            n_total++;
            if (o.own_rv !== 1'b1 || o.other_rv !== 1'b0 || o.err !== e_err ||
                o.rdata !== e_rd || o.extra_rv !== 1'b0)
                $display("FAIL rand[%0d]_resp: got rv=%b orv=%b err=%b rdata=%h extra=%b want 1/0/%b/%h/0",
                         i, o.own_rv, o.other_rv, o.err, o.rdata, o.extra_rv, e_err, e_rd);
            else n_pass++;
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_hb_i = '0; d_ul_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) step();
        test_reset();
        test_fetch();
        test_byte_load();
        test_half_store();
        test_starvation();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester (program pointer side) and the data requester (decode/execute load/store controls). It enforces one outstanding transaction at a time and applies data-over-fetch priority with a starvation guard. It also generates byte enables and write-lane replication from the hb/ul size encoding, and aligns and sign- or zero-extends load data. It sits between the decode/execute stages and the memory bus.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win; range 1..15
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until granted
- if_addr_i  in  32  fetch address
- if_gnt_o  out  1  fetch granted (combinational, IDLE only)
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  32  instruction word
- d_req_i  in  1  data request; held until granted
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data, right-justified
- d_hb_i  in  2  size: 00 word, 01 byte, 10 half, 11 illegal
- d_ul_i  in  1  load unsigned
- d_gnt_o  out  1  data granted (combinational, IDLE only)
- d_rvalid_o  out  1  load data or store ack valid, one-cycle pulse
- d_rdata_o  out  32  extended load data; 0 for stores and errors
- d_err_o  out  1  misaligned/illegal-size flag, valid with d_rvalid_o
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  32  bus address, always word-aligned
- mem_wdata_o  out  32  lane-replicated write data
- mem_be_o  out  4  byte enables
- mem_gnt_i  in  1  bus accepted request
- mem_rvalid_i  in  1  bus response (read data or write ack)
- mem_rdata_i  in  32  bus read word

## Operation
- States:
  - IDLE: if any request is present and the arbitration winner is legal → ISSUE; if the winner is a data request with an error → RESP_ERR; otherwise stay.
  - ISSUE: hold mem_req_o = 1 with stable bus fields; mem_gnt_i → WAIT.
  - WAIT: mem_rvalid_i → RESP.
  - RESP: pulse the owner's rvalid_o for one cycle → IDLE.
  - RESP_ERR: pulse d_rvalid_o = 1 and d_err_o = 1 for one cycle → IDLE.
- Arbitration in IDLE: data wins unless starve_cnt == STARVE_LIMIT and if_req_i = 1, in which case fetch wins.
- starve_cnt: increments on each data grant while if_req_i = 1; clears on a fetch grant or whenever if_req_i = 0; saturates at STARVE_LIMIT.
- At grant, the arbiter latches owner, we, addr, hb, ul and wdata; requesters may change their inputs after the gnt cycle.
- Fetch: mem_we_o = 0, mem_be_o = 1111, mem_addr_o = {if_addr_i[31:2], 00}; if_addr_i[1:0] are ignored.
- Data, byte: mem_be_o = 0001 << addr[1:0]; mem_wdata_o = the byte replicated ×4.
- Data, half: mem_be_o = 0011 << {addr[1], 0}; mem_wdata_o = the half replicated ×2.
- Data, word: mem_be_o = 1111.
- Error conditions: half with addr[0] = 1, word with addr[1:0] ≠ 0, or hb = 11. No bus access is made.
- Load result: select the lane using the latched addr[1:0], then extend. ul = 1 zero-extends; ul = 0 sign-extends. Word loads pass through unchanged.
- Store response: d_rdata_o = 0.
- A mem_rvalid_i seen outside WAIT is ignored.
- Reset: async to IDLE. All outputs are 0 and starve_cnt = 0. An in-flight bus response arriving after reset is dropped.

## Timing
- Grant cycle is T: gnt_o is high in T and latches are written at the T edge.
- mem_req_o rises in T+1 and falls the cycle after the mem_gnt_i sample.
- rvalid_o pulses in the cycle after the mem_rvalid_i sample; rdata is registered.
- Minimum legal latency: req/gnt in T, mem_gnt_i in T+1, mem_rvalid_i in T+2, rvalid_o in T+3.
- Next grant is possible in the RESP cycle + 1, which gives a back-to-back throughput of 1 access per 4 cycles.
- Error latency: gnt in T, d_rvalid_o and d_err_o in T+1.
- Simultaneous if_req_i and d_req_i: exactly one gnt_o is high in any cycle. gnt_o is never high outside IDLE.
- mem_gnt_i and mem_rvalid_i in the same cycle while in ISSUE: the response is ignored. The bus never returns a response before accepting the request.

## Structure
- Shared package core_pkg:
  - HB_WORD = 2'b00, HB_BYTE = 2'b01, HB_HALF = 2'b10
  - OWNER_IF, OWNER_D
  - arbiter state enum {IDLE, ISSUE, WAIT, RESP, RESP_ERR}
- One sub-module, load_formatter: combinational lane select plus sign/zero extension. Inputs: word, addr[1:0], hb, ul; output: 32-bit result.

## Test plan
- Fetch only:
  - Stimulus: if_addr_i = 0x0000_0106, memory returns 0x00A0_0093 with gnt at +1 and rvalid at +2.
  - Required: mem_addr_o = 0x104, be = 1111, if_rvalid_o in T+3 with 0x00A0_0093.
- Byte load, signed vs unsigned:
  - Stimulus: addr 0x203, hb = 01, rdata 0x80FF_1234; run with ul = 0 and with ul = 1.
  - Required: be = 1000; d_rdata_o = 0xFFFF_FF80 (ul = 0) and 0x0000_0080 (ul = 1).
- Half store:
  - Stimulus: addr 0x302, wdata 0x1234_ABCD.
  - Required: mem_we_o = 1, be = 1100, mem_wdata_o = 0xABCD_ABCD, d_rvalid_o with rdata 0.
- Starvation guard:
  - Stimulus: STARVE_LIMIT = 4; both requests held continuously.
  - Required: grant order D, D, D, D, IF, D…; never two gnt_o high in the same cycle.
- Misaligned access:
  - Stimulus: word load at addr 0x401.
  - Required: mem_req_o stays 0; d_rvalid_o = d_err_o = 1 in T+1, rdata = 0; the next fetch proceeds normally.
- Reset mid-transaction:
  - Stimulus: assert rst_ni = 0 while in WAIT, release, then the memory delivers the late rvalid.
  - Required: all outputs 0 during reset; the late rvalid is ignored; no rvalid_o pulse.
